// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared 16-bit combinational ALU.
// Grants one of two requesters, drives registered ALU operands, returns the result.
module alu_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [DATA_W-1:0] a_req_in1,
  input  logic [DATA_W-1:0] a_req_in2,
  input  logic [MODE_W-1:0] a_req_mode,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [DATA_W-1:0] b_req_in1,
  input  logic [DATA_W-1:0] b_req_in2,
  input  logic [MODE_W-1:0] b_req_mode,
  output logic              a_rsp_valid,
  input  logic              a_rsp_ready,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [MODE_W-1:0] alu_mode,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              r_state;
  logic                r_prio;
  logic                r_gnt;
  logic [DATA_W-1:0]   r_alu_in1;
  logic [DATA_W-1:0]   r_alu_in2;
  logic [MODE_W-1:0]   r_alu_mode;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_a_rsp_valid;
  logic                r_b_rsp_valid;
  logic                r_busy;

  logic w_idle;
  logic w_sel;
  logic w_accept;
  logic w_rsp_hs;

  // w_sel picks B when only B is valid, or both are valid and B holds priority.
  assign w_idle      = (r_state == IDLE);
  assign w_sel       = b_req_valid & (~a_req_valid | r_prio);
  assign a_req_ready = w_idle & a_req_valid & ~w_sel;
  assign b_req_ready = w_idle & b_req_valid & w_sel;
  assign w_accept    = a_req_ready | b_req_ready;
  assign w_rsp_hs    = r_gnt ? b_rsp_ready : a_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_prio        <= 1'b0;
      r_gnt         <= 1'b0;
      r_alu_in1     <= '0;
      r_alu_in2     <= '0;
      r_alu_mode    <= '0;
      r_rsp_data    <= '0;
      r_a_rsp_valid <= 1'b0;
      r_b_rsp_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_alu_in1  <= w_sel ? b_req_in1  : a_req_in1;
            r_alu_in2  <= w_sel ? b_req_in2  : a_req_in2;
            r_alu_mode <= w_sel ? b_req_mode : a_req_mode;
            r_gnt      <= w_sel;
            r_busy     <= 1'b1;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_data    <= alu_out;
          r_a_rsp_valid <= ~r_gnt;
          r_b_rsp_valid <= r_gnt;
          r_state       <= RESP;
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_prio        <= ~r_gnt;
            r_a_rsp_valid <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a_rsp_valid = r_a_rsp_valid;
  assign b_rsp_valid = r_b_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign alu_in1     = r_alu_in1;
  assign alu_in2     = r_alu_in2;
  assign alu_mode    = r_alu_mode;
  assign busy        = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; includes a behavioural model of the shared ALU
// (shift amount taken from in2[3:0], NOT operates on in1).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req_valid, a_req_ready, b_req_valid, b_req_ready;
  logic [15:0] a_req_in1, a_req_in2, b_req_in1, b_req_in2;
  logic [2:0]  a_req_mode, b_req_mode;
  logic        a_rsp_valid, a_rsp_ready, b_rsp_valid, b_rsp_ready;
  logic [15:0] rsp_data, alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_mode;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_mode)
      3'd0:    alu_out = alu_in1 + alu_in2;
      3'd1:    alu_out = alu_in1 - alu_in2;
      3'd2:    alu_out = alu_in1 >> alu_in2[3:0];
      3'd3:    alu_out = alu_in1 << alu_in2[3:0];
      3'd4:    alu_out = alu_in1 & alu_in2;
      3'd5:    alu_out = alu_in1 | alu_in2;
      3'd6:    alu_out = ~alu_in1;
      default: alu_out = alu_in1 ^ alu_in2;
    endcase
  end

  alu_arbiter #(.DATA_W(16), .MODE_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_req_in1(a_req_in1), .a_req_in2(a_req_in2), .a_req_mode(a_req_mode),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_req_in1(b_req_in1), .b_req_in2(b_req_in2), .b_req_mode(b_req_mode),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
    .rsp_data(rsp_data), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_mode(alu_mode), .alu_out(alu_out), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit port, input logic [15:0] d1, input logic [15:0] d2,
                     input logic [2:0] m, input logic [15:0] exp, input string tag);
    int unsigned k;
    if (port) begin
      b_req_valid = 1'b1; b_req_in1 = d1; b_req_in2 = d2; b_req_mode = m;
    end else begin
      a_req_valid = 1'b1; a_req_in1 = d1; a_req_in2 = d2; a_req_mode = m;
    end
    #1;
    k = 0;
    while (!(port ? b_req_ready : a_req_ready) && k < 20) begin step(); k++; end
    chk({tag, "_rdy"}, port ? b_req_ready : a_req_ready, 1);
    step();
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    k = 0;
    while (!(port ? b_rsp_valid : a_rsp_valid) && k < 20) begin step(); k++; end
    chk({tag, "_lat"}, k, 1);
    chk({tag, "_data"}, rsp_data, exp);
    chk({tag, "_other"}, port ? a_rsp_valid : b_rsp_valid, 0);
    step();
    chk({tag, "_drop"}, port ? b_rsp_valid : a_rsp_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_req_valid = 0; a_req_in1 = 0; a_req_in2 = 0; a_req_mode = 0;
    b_req_valid = 0; b_req_in1 = 0; b_req_in2 = 0; b_req_mode = 0;
    a_rsp_ready = 1; b_rsp_ready = 1;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_alu", {alu_in1, alu_in2}, 0);
    chk("rst_rsp", {a_rsp_valid, b_rsp_valid, rsp_data}, 0);
    chk("rst_rdy_idle", {a_req_ready, b_req_ready}, 0);
    rst_n = 1'b1;
    step();

    // Single SUBST with cycle-by-cycle checks
    a_req_valid = 1; a_req_in1 = 16'd100; a_req_in2 = 16'd35; a_req_mode = 3'd1;
    #1;
    chk("sub_rdy_c0", a_req_ready, 1);
    step();
    a_req_valid = 0;
    chk("sub_in1_c1", alu_in1, 100);
    chk("sub_mode_c1", alu_mode, 1);
    chk("sub_busy_c1", busy, 1);
    chk("sub_rdy_exec", a_req_ready, 0);
    step();
    chk("sub_vld_c2", a_rsp_valid, 1);
    chk("sub_data_c2", rsp_data, 65);
    chk("sub_bvld_c2", b_rsp_valid, 0);
    step();
    chk("sub_drop", {a_rsp_valid, busy}, 0);

    txn(1'b1, 16'd0, 16'd32766, 3'd1, 16'h8002, "wrap");

    // Reset asserted while EXEC is in progress
    a_req_valid = 1; a_req_in1 = 16'h1234; a_req_in2 = 16'h1111; a_req_mode = 3'd0;
    #1;
    step();
    a_req_valid = 0;
    chk("mid_busy", busy, 1);
    chk("mid_in1", alu_in1, 16'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_alu", {alu_in1, alu_in2, 13'd0, alu_mode}, 0);
    chk("mid_rst_rsp", {a_rsp_valid, b_rsp_valid, rsp_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn(1'b0, 16'h1234, 16'h1111, 3'd0, 16'h2345, "post_rst");

    // Contention from reset: A, B, A
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step();
    a_req_valid = 1; a_req_in1 = 3; a_req_in2 = 4; a_req_mode = 3'd0;
    b_req_valid = 1; b_req_in1 = 16'h00FF; b_req_in2 = 16'h0F0F; b_req_mode = 3'd7;
    #1;
    chk("cont_rdy1", {a_req_ready, b_req_ready}, 2'b10);
    step(); step();
    chk("cont_rsp1", {a_rsp_valid, b_rsp_valid, rsp_data}, {2'b10, 16'd7});
    step();
    chk("cont_rdy2", {a_req_ready, b_req_ready}, 2'b01);
    step(); step();
    chk("cont_rsp2", {a_rsp_valid, b_rsp_valid, rsp_data}, {2'b01, 16'h0FF0});
    step();
    chk("cont_rdy3", {a_req_ready, b_req_ready}, 2'b10);
    a_req_valid = 0; b_req_valid = 0;

    // Backpressure on A with B pending
    a_rsp_ready = 0;
    a_req_valid = 1; a_req_in1 = 1; a_req_in2 = 2; a_req_mode = 3'd0;
    b_req_valid = 1; b_req_in1 = 5; b_req_in2 = 3; b_req_mode = 3'd7;
    #1;
    chk("bp_rdy", {a_req_ready, b_req_ready}, 2'b10);
    step();
    a_req_valid = 0;
    chk("bp_brdy_exec", b_req_ready, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {a_rsp_valid, busy, b_req_ready, rsp_data}, {3'b110, 16'd3});
      step();
    end
    a_rsp_ready = 1;
    step();
    chk("bp_release", {a_rsp_valid, b_req_ready}, 2'b01);
    step();
    b_req_valid = 0;
    step();
    chk("bp_brsp", {b_rsp_valid, rsp_data}, {1'b1, 16'd6});
    step();

    txn(1'b0, 16'hF00F, 16'h0003, 3'd0, 16'hF012, "m_add");
    txn(1'b0, 16'hF00F, 16'h0003, 3'd1, 16'hF00C, "m_sub");
    txn(1'b0, 16'hF00F, 16'h0003, 3'd2, 16'h1E01, "m_shr");
    txn(1'b0, 16'hF00F, 16'h0003, 3'd3, 16'h8078, "m_shl");
    txn(1'b0, 16'hF00F, 16'h0003, 3'd4, 16'h0003, "m_and");
    txn(1'b0, 16'hF00F, 16'h0003, 3'd5, 16'hF00F, "m_or");
    txn(1'b0, 16'hF00F, 16'h0003, 3'd6, 16'h0FF0, "m_not");
    txn(1'b0, 16'hF00F, 16'h0003, 3'd7, 16'hF00C, "m_xor");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
